// File: rtl/hyperram_arbiter.sv
// hyperram_arbiter: two-client round-robin arbiter and transaction sequencer for the HyperRAM wrapper.
// Defining HRAM_ARB_TIMEOUT_EN adds a read watchdog that aborts RD_WAIT after TIMEOUT_CYCLES without a beat.
module hyperram_arbiter #(
   parameter int unsigned MAX_WORDS      = 512,
   parameter logic [2:0]  LATENCY        = 3'd6,
   parameter int unsigned WR_OVERHEAD    = 64,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_ready_i,
   input  logic        req0_valid_i,
   input  logic        req0_write_i,
   input  logic [31:0] req0_addr_i,
   input  logic [31:0] req0_num_words_i,
   output logic        req0_grant_o,
   input  logic [31:0] req0_wr_data_i,
   input  logic        req0_wr_valid_i,
   output logic        req0_wr_ready_o,
   output logic [31:0] req0_rd_data_o,
   output logic        req0_rd_valid_o,
   output logic        req0_done_o,
   output logic        req0_err_o,
   input  logic        req1_valid_i,
   input  logic        req1_write_i,
   input  logic [31:0] req1_addr_i,
   input  logic [31:0] req1_num_words_i,
   output logic        req1_grant_o,
   input  logic [31:0] req1_wr_data_i,
   input  logic        req1_wr_valid_i,
   output logic        req1_wr_ready_o,
   output logic [31:0] req1_rd_data_o,
   output logic        req1_rd_valid_o,
   output logic        req1_done_o,
   output logic        req1_err_o,
   output logic        ctrl_cs_o,
   output logic [1:0]  ctrl_mode_o,
   output logic [31:0] ctrl_num_words_o,
   output logic [2:0]  ctrl_latency_o,
   output logic [31:0] ctrl_addr_in_o,
   output logic [31:0] ctrl_wr_data_in_o,
   output logic        ctrl_wr_data_valid_o,
   input  logic [31:0] ctrl_rd_data_out_i,
   input  logic        ctrl_rd_data_valid_i
);
   typedef enum logic [2:0] {IDLE, WR_FILL, START, RD_WAIT, WR_DRAIN, DONE} state_t;
   state_t      state_q, state_d;
   logic        owner_q, owner_d, last_q, last_d, write_q, write_d, err_q, err_d;
   logic [31:0] addr_q, addr_d, num_q, num_d, wdat_q, wdat_d;
   logic [32:0] cnt_q, cnt_d;
   logic [1:0]  grant_q, grant_d;
   logic [2:0]  lat_q, lat_d;
   logic        wval_q, wval_d;
   logic        pick, fill_rdy, rd_act, wr_acc, req_write;
   logic [31:0] req_addr, req_num;
   logic [32:0] num_ext, drain_end;
`ifdef HRAM_ARB_TIMEOUT_EN
   localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 2);
   logic [31:0] wdog_q, wdog_d;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         num_q   <= '0;
         wdat_q  <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         lat_q   <= '0;
         wval_q  <= 1'b0;
`ifdef HRAM_ARB_TIMEOUT_EN
         wdog_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         write_q <= write_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         num_q   <= num_d;
         wdat_q  <= wdat_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         lat_q   <= lat_d;
         wval_q  <= wval_d;
`ifdef HRAM_ARB_TIMEOUT_EN
         wdog_q  <= wdog_d;
`endif
      end
   end
   assign pick      = (req0_valid_i && req1_valid_i) ? !last_q : req1_valid_i;
   assign req_write = pick ? req1_write_i : req0_write_i;
   assign req_addr  = pick ? req1_addr_i : req0_addr_i;
   assign req_num   = pick ? req1_num_words_i : req0_num_words_i;
   assign num_ext   = {1'b0, num_q};
   assign drain_end = num_ext + 33'(WR_OVERHEAD);
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      write_d = write_q;
      err_d   = err_q;
      addr_d  = addr_q;
      num_d   = num_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      wdat_d  = wdat_q;
      grant_d = 2'b00;
      wval_d  = 1'b0;
`ifdef HRAM_ARB_TIMEOUT_EN
      wdog_d  = wdog_q;
`endif
      case (state_q)
         IDLE: if (mem_ready_i && (req0_valid_i || req1_valid_i)) begin
            owner_d = pick;
            last_d  = pick;
            grant_d = pick ? 2'b10 : 2'b01;
            write_d = req_write;
            addr_d  = req_addr;
            num_d   = req_num;
            lat_d   = LATENCY;
            cnt_d   = '0;
            err_d   = req_num > MAX_WORDS;
            state_d = (req_num == '0 || req_num > MAX_WORDS) ? DONE : (req_write ? WR_FILL : START);
         end
         WR_FILL: begin
            if (wr_acc) begin
               cnt_d  = cnt_q + 33'd1;
               wdat_d = owner_q ? req1_wr_data_i : req0_wr_data_i;
               wval_d = 1'b1;
            end
            // Extra cycle at count == num_words lets the last FIFO push land before the start pulse.
            if (cnt_q == num_ext) state_d = START;
         end
         START: begin
            cnt_d   = '0;
            state_d = write_q ? WR_DRAIN : RD_WAIT;
`ifdef HRAM_ARB_TIMEOUT_EN
            wdog_d  = '0;
`endif
         end
         RD_WAIT: begin
            if (ctrl_rd_data_valid_i) begin
               cnt_d = cnt_q + 33'd1;
               if (cnt_q + 33'd1 == num_ext) state_d = DONE;
            end
`ifdef HRAM_ARB_TIMEOUT_EN
            // DONE lands exactly TIMEOUT_CYCLES cycles after the last beat.
            wdog_d = ctrl_rd_data_valid_i ? '0 : wdog_q + 32'd1;
            if (!ctrl_rd_data_valid_i && wdog_q == WD_LAST) begin
               state_d = DONE;
               err_d   = 1'b1;
            end
`endif
         end
         WR_DRAIN: begin
            cnt_d = cnt_q + 33'd1;
            if (cnt_q + 33'd2 >= drain_end) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      fill_rdy             = state_q == WR_FILL && cnt_q < num_ext;
      rd_act               = state_q == RD_WAIT;
      wr_acc               = fill_rdy && (owner_q ? req1_wr_valid_i : req0_wr_valid_i);
      req0_grant_o         = grant_q[0];
      req1_grant_o         = grant_q[1];
      req0_wr_ready_o      = fill_rdy && !owner_q;
      req1_wr_ready_o      = fill_rdy && owner_q;
      req0_rd_valid_o      = rd_act && !owner_q && ctrl_rd_data_valid_i;
      req1_rd_valid_o      = rd_act && owner_q && ctrl_rd_data_valid_i;
      req0_rd_data_o       = (rd_act && !owner_q) ? ctrl_rd_data_out_i : '0;
      req1_rd_data_o       = (rd_act && owner_q) ? ctrl_rd_data_out_i : '0;
      req0_done_o          = state_q == DONE && !owner_q;
      req1_done_o          = state_q == DONE && owner_q;
      req0_err_o           = req0_done_o && err_q;
      req1_err_o           = req1_done_o && err_q;
      ctrl_cs_o            = state_q == START;
      ctrl_mode_o          = {1'b0, write_q};
      ctrl_num_words_o     = num_q;
      ctrl_latency_o       = lat_q;
      ctrl_addr_in_o       = addr_q;
      ctrl_wr_data_in_o    = wdat_q;
      ctrl_wr_data_valid_o = wval_q;
   end
endmodule

// File: tb/tb_hyperram_arbiter.sv
// tb_hyperram_arbiter: scoreboard bench for hyperram_arbiter (read, write, round-robin, edge lengths, mem_ready, reset).
// The watchdog scenario runs only when HRAM_ARB_TIMEOUT_EN is defined.
module tb_hyperram_arbiter;
   logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b1;
   logic req0_valid = 0, req0_write = 0, req0_wr_valid = 0, req1_valid = 0, req1_write = 0, req1_wr_valid = 0;
   logic [31:0] req0_addr = 0, req0_num = 0, req0_wr_data = 0, req1_addr = 0, req1_num = 0, req1_wr_data = 0;
   logic req0_grant, req0_wr_ready, req0_rd_valid, req0_done, req0_err;
   logic req1_grant, req1_wr_ready, req1_rd_valid, req1_done, req1_err;
   logic [31:0] req0_rd_data, req1_rd_data, ctrl_num_words, ctrl_addr_in, ctrl_wr_data_in;
   logic ctrl_cs, ctrl_wr_data_valid, ctrl_rd_data_valid = 0;
   logic [1:0] ctrl_mode;
   logic [2:0] ctrl_latency;
   logic [31:0] ctrl_rd_data_out = 0;
   int checks = 0, failures = 0, cyc = 0, last_m = 1;
   int grant_q[$];
   logic [1:0] done_q[$], cs_mode_q[$];
   logic [31:0] rd0_q[$], rd1_q[$], wr_q[$], cs_addr_q[$], cs_num_q[$];
   logic any_out;

   hyperram_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .mem_ready_i(mem_ready),
      .req0_valid_i(req0_valid), .req0_write_i(req0_write), .req0_addr_i(req0_addr),
      .req0_num_words_i(req0_num), .req0_grant_o(req0_grant), .req0_wr_data_i(req0_wr_data),
      .req0_wr_valid_i(req0_wr_valid), .req0_wr_ready_o(req0_wr_ready), .req0_rd_data_o(req0_rd_data),
      .req0_rd_valid_o(req0_rd_valid), .req0_done_o(req0_done), .req0_err_o(req0_err),
      .req1_valid_i(req1_valid), .req1_write_i(req1_write), .req1_addr_i(req1_addr),
      .req1_num_words_i(req1_num), .req1_grant_o(req1_grant), .req1_wr_data_i(req1_wr_data),
      .req1_wr_valid_i(req1_wr_valid), .req1_wr_ready_o(req1_wr_ready), .req1_rd_data_o(req1_rd_data),
      .req1_rd_valid_o(req1_rd_valid), .req1_done_o(req1_done), .req1_err_o(req1_err),
      .ctrl_cs_o(ctrl_cs), .ctrl_mode_o(ctrl_mode), .ctrl_num_words_o(ctrl_num_words),
      .ctrl_latency_o(ctrl_latency), .ctrl_addr_in_o(ctrl_addr_in), .ctrl_wr_data_in_o(ctrl_wr_data_in),
      .ctrl_wr_data_valid_o(ctrl_wr_data_valid), .ctrl_rd_data_out_i(ctrl_rd_data_out),
      .ctrl_rd_data_valid_i(ctrl_rd_data_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign any_out = |{req0_grant, req0_wr_ready, req0_rd_data, req0_rd_valid, req0_done, req0_err,
                      req1_grant, req1_wr_ready, req1_rd_data, req1_rd_valid, req1_done, req1_err,
                      ctrl_cs, ctrl_mode, ctrl_num_words, ctrl_latency, ctrl_addr_in, ctrl_wr_data_in,
                      ctrl_wr_data_valid};

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic sig(input int k);
      case (k)
         0: return req0_grant;
         1: return req1_grant;
         2: return ctrl_cs;
         3: return req0_done;
         4: return req1_done;
         5: return req0_wr_ready;
         6: return req1_wr_ready;
         default: return req0_grant | req1_grant;
      endcase
   endfunction

   task automatic wait_neg(input int k, input string tag, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sig(k) && n < 300);
      chk(tag, sig(k), 1);
   endtask

   // Scoreboard: every DUT output event pops the oldest expectation of its kind.
   always @(negedge clk) if (rst_n) begin
      if (req0_grant || req1_grant) begin
         if (grant_q.size() == 0) chk("grant_unexp", grant_q.size(), 1);
         else chk("grant_who", {req1_grant, req0_grant}, grant_q.pop_front() ? 2'b10 : 2'b01);
      end
      if (req0_done || req1_done) begin
         if (done_q.size() == 0) chk("done_unexp", done_q.size(), 1);
         else chk("done_who_err", {req1_done, req1_done ? req1_err : req0_err}, done_q.pop_front());
      end
      if (ctrl_cs) begin
         if (cs_mode_q.size() == 0) chk("cs_unexp", cs_mode_q.size(), 1);
         else begin
            chk("cs_mode", ctrl_mode, cs_mode_q.pop_front());
            chk("cs_addr", ctrl_addr_in, cs_addr_q.pop_front());
            chk("cs_num", ctrl_num_words, cs_num_q.pop_front());
            chk("cs_lat", ctrl_latency, 3'd6);
         end
      end
      if (ctrl_wr_data_valid) begin
         if (wr_q.size() == 0) chk("push_unexp", wr_q.size(), 1);
         else chk("push_data", ctrl_wr_data_in, wr_q.pop_front());
      end
      if (req0_rd_valid) begin
         if (rd0_q.size() == 0) chk("rd0_unexp", rd0_q.size(), 1);
         else chk("rd0_data", req0_rd_data, rd0_q.pop_front());
      end
      if (req1_rd_valid) begin
         if (rd1_q.size() == 0) chk("rd1_unexp", rd1_q.size(), 1);
         else chk("rd1_data", req1_rd_data, rd1_q.pop_front());
      end
   end

   task automatic req(input int c, input logic wr, input logic [31:0] addr, input logic [31:0] num);
      int n;
      grant_q.push_back(c);
      last_m = c;
      if (num == 0) done_q.push_back({c[0], 1'b0});
      else if (num > 512) done_q.push_back({c[0], 1'b1});
      else begin
         cs_mode_q.push_back({1'b0, wr});
         cs_addr_q.push_back(addr);
         cs_num_q.push_back(num);
      end
      @(posedge clk); #1;
      if (c == 0) begin
         req0_valid = 1; req0_write = wr; req0_addr = addr; req0_num = num;
      end else begin
         req1_valid = 1; req1_write = wr; req1_addr = addr; req1_num = num;
      end
      wait_neg(c, "grant_seen", n);
      chk("grant_lat", n, 2);
      req0_valid = 0;
      req1_valid = 0;
   endtask

   task automatic rd_body(input int c, input int num, input logic [31:0] base);
      chk("rd_cs_with_grant", ctrl_cs, 1);
      done_q.push_back({c[0], 1'b0});
      for (int i = 0; i < num; i++) begin
         @(posedge clk); #1;
         ctrl_rd_data_valid = 1;
         ctrl_rd_data_out = base + 32'(i);
         if (c == 0) rd0_q.push_back(base + 32'(i));
         else rd1_q.push_back(base + 32'(i));
      end
      @(posedge clk); #1;
      ctrl_rd_data_valid = 0;
      @(negedge clk);
      chk("rd_done_next", sig(3 + c), 1);
   endtask

   task automatic rd_txn(input int c, input logic [31:0] addr, input int num, input logic [31:0] base);
      req(c, 1'b0, addr, 32'(num));
      rd_body(c, num, base);
   endtask

   task automatic wr_txn(input int c, input logic [31:0] addr, input int num, input logic [31:0] step);
      int n, t;
      logic [31:0] d;
      req(c, 1'b1, addr, 32'(num));
      done_q.push_back({c[0], 1'b0});
      for (int i = 0; i < num; i++) begin
         @(posedge clk); #1;
         d = step * 32'(i + 1);
         if (c == 0) begin
            req0_wr_valid = 1; req0_wr_data = d; req1_wr_valid = 1; req1_wr_data = 32'hDEAD_BEEF;
         end else begin
            req1_wr_valid = 1; req1_wr_data = d; req0_wr_valid = 1; req0_wr_data = 32'hDEAD_BEEF;
         end
         n = 0;
         do begin
            @(negedge clk);
            n++;
            chk("wr_other_rdy", sig(6 - c), 0);
         end while (!sig(5 + c) && n < 20);
         chk("wr_rdy", sig(5 + c), 1);
         wr_q.push_back(d);
      end
      @(posedge clk); #1;
      req0_wr_valid = 0;
      req1_wr_valid = 0;
      wait_neg(2, "wr_cs", n);
      t = cyc;
      wait_neg(3 + c, "wr_done", n);
      chk("wr_done_lat", cyc - t, num + 64);
   endtask

   initial begin
      int n, ex;
      repeat (2) begin
         @(negedge clk);
         chk("rst_outs", any_out, 0);
      end
      @(posedge clk); #1;
      rst_n = 1;
      rd_txn(0, 32'h100, 4, 32'hA0);
      wr_txn(1, 32'h80, 3, 32'h11);
      // Both clients hold valid across four one-word reads.
      @(posedge clk); #1;
      req0_valid = 1; req0_write = 0; req0_addr = 32'h500; req0_num = 1;
      req1_valid = 1; req1_write = 0; req1_addr = 32'h600; req1_num = 1;
      for (int k = 0; k < 4; k++) begin
         ex = last_m ? 0 : 1;
         last_m = ex;
         grant_q.push_back(ex);
         cs_mode_q.push_back(2'b00);
         cs_addr_q.push_back(ex ? 32'h600 : 32'h500);
         cs_num_q.push_back(1);
         wait_neg(7, "sim_grant", n);
         if (k == 3) begin
            req0_valid = 0;
            req1_valid = 0;
         end
         rd_body(ex, 1, 32'hC0 + 32'(k));
      end
      req(0, 1'b0, 32'h10, 0);
      chk("zero_done", req0_done, 1);
      chk("zero_err", req0_err, 0);
      req(1, 1'b1, 32'h20, 513);
      chk("big_done", req1_done, 1);
      chk("big_err", req1_err, 1);
      @(posedge clk); #1;
      mem_ready = 0;
      req0_valid = 1; req0_write = 0; req0_addr = 32'h700; req0_num = 1;
      repeat (5) begin
         @(negedge clk);
         chk("mr_hold", req0_grant, 0);
      end
      @(posedge clk); #1;
      mem_ready = 1;
      grant_q.push_back(0);
      last_m = 0;
      cs_mode_q.push_back(2'b00);
      cs_addr_q.push_back(32'h700);
      cs_num_q.push_back(1);
      wait_neg(0, "mr_grant", n);
      chk("mr_grant_lat", n, 2);
      req0_valid = 0;
      rd_body(0, 1, 32'hD0);
      // Abort a read after 2 of 8 beats.
      req(1, 1'b0, 32'h200, 8);
      chk("rst_cs", ctrl_cs, 1);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         ctrl_rd_data_valid = 1;
         ctrl_rd_data_out = 32'hF0 + 32'(i);
         rd1_q.push_back(32'hF0 + 32'(i));
      end
      @(posedge clk); #1;
      ctrl_rd_data_valid = 0;
      rst_n = 0;
      #1;
      chk("rst_mid_outs", any_out, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      last_m = 1;
      rd_txn(0, 32'h300, 2, 32'hE0);
      @(posedge clk); #1;
      ctrl_rd_data_valid = 1;
      ctrl_rd_data_out = 32'hBAD;
      @(negedge clk);
      chk("idle_rd_block", req0_rd_valid | req1_rd_valid, 0);
      @(posedge clk); #1;
      ctrl_rd_data_valid = 0;
`ifdef HRAM_ARB_TIMEOUT_EN
      begin
         int b;
         req(0, 1'b0, 32'h400, 4);
         done_q.push_back(2'b01);
         @(posedge clk); #1;
         ctrl_rd_data_valid = 1;
         ctrl_rd_data_out = 32'hA0;
         rd0_q.push_back(32'hA0);
         b = cyc;
         @(posedge clk); #1;
         ctrl_rd_data_valid = 0;
         wait_neg(3, "to_done", n);
         chk("to_lat", cyc - b, 16);
         chk("to_err", req0_err, 1);
         @(posedge clk); #1;
         ctrl_rd_data_valid = 1;
         @(posedge clk); #1;
         ctrl_rd_data_valid = 0;
      end
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("left_grant", grant_q.size(), 0);
      chk("left_done", done_q.size(), 0);
      chk("left_cs", cs_mode_q.size(), 0);
      chk("left_push", wr_q.size(), 0);
      chk("left_rd", rd0_q.size() + rd1_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/hyperram_arbiter.md
Name: hyperram_arbiter

Overview:
Two-requester round-robin arbiter and transaction sequencer in front of the HyperRAM interface wrapper (write FIFO plus DDR PHY).
- Accepts burst read/write requests from two clients and grants one at a time.
- For writes, preloads the wrapper's write FIFO, then issues a one-cycle ctrl_cs start pulse.
- Tracks completion by counting read beats or draining writes, and returns data/done to the owning client.

Parameters:
MAX_WORDS, 512, write FIFO depth; largest legal num_words for any request.
LATENCY, 3'd6, value driven on ctrl_latency for every transaction.
WR_OVERHEAD, 64, extra clk cycles after the write start pulse (beyond num_words) before the write is considered complete.
TIMEOUT_CYCLES, 4096, read watchdog limit (optional feature only).

Ports:
clk  in  1  system clock; same domain as the wrapper's clk.
rst_n  in  1  asynchronous active-low reset.
mem_ready  in  1  wrapper ready (FIFO out of reset).
reqN_valid  in  1  (N=0,1) request pending; held until reqN_grant.
reqN_write  in  1  1 = write, 0 = read.
reqN_addr  in  32  start address.
reqN_num_words  in  32  burst length in 32-bit words.
reqN_grant  out  1  one-cycle pulse: request accepted, parameters latched.
reqN_wr_data  in  32  write data.
reqN_wr_valid  in  1  write data valid.
reqN_wr_ready  out  1  arbiter accepts write data this cycle.
reqN_rd_data  out  32  read data.
reqN_rd_valid  out  1  read data valid.
reqN_done  out  1  one-cycle pulse at transaction end.
reqN_err  out  1  qualifies reqN_done: transaction rejected or aborted.
ctrl_cs  out  1  one-cycle start pulse to the wrapper.
ctrl_mode  out  2  2'b00 = read, 2'b01 = write; stable from START until DONE.
ctrl_num_words  out  32  latched burst length.
ctrl_latency  out  3  = LATENCY.
ctrl_addr_in  out  32  latched address.
ctrl_wr_data_in  out  32  write data into the wrapper FIFO (registered).
ctrl_wr_data_valid  out  1  FIFO push strobe (registered).
ctrl_rd_data_out  in  32  read data from the wrapper.
ctrl_rd_data_valid  in  1  read beat strobe.

Behaviour:
Reset:
- All outputs 0; ctrl_mode = 2'b00.
- State = IDLE; counters 0; last_grant = 1, so req0 wins first.
- Reset asserted mid-transaction aborts immediately: ctrl_cs and strobes drop, and no done is issued.

States: IDLE, WR_FILL, START, RD_WAIT, WR_DRAIN, DONE.

IDLE:
- Arbitrates only when mem_ready = 1. If mem_ready = 0, no grants are issued and requests wait.
- Sampling at edge N gives reqN_grant = 1 in cycle N+1; addr, num_words and write are latched at the same edge.
- Both valid: grant the requester not in last_grant, then update last_grant. Single valid: grant it.
- num_words == 0: grant, then DONE with err = 0; no memory access.
- num_words > MAX_WORDS: grant, then DONE with err = 1.
- Otherwise: a write goes to WR_FILL, a read goes to START.

WR_FILL:
- Owner's wr_ready = 1 while count < num_words; the other client's wr_ready = 0.
- Each wr_valid & wr_ready beat drives ctrl_wr_data_in/ctrl_wr_data_valid one cycle later and increments count.
- At count == num_words, wr_ready drops the same cycle and the state goes to START.

START:
- ctrl_cs = 1 for exactly one cycle, with ctrl_mode, ctrl_addr_in and ctrl_num_words valid and stable.
- Count resets to 0. Next state is RD_WAIT for a read, WR_DRAIN for a write.

RD_WAIT:
- Owner's rd_data = ctrl_rd_data_out and rd_valid = ctrl_rd_data_valid, combinational pass-through. The non-owner's rd_valid = 0.
- Count increments per beat. The beat that makes count == num_words is forwarded, then the state goes to DONE.

WR_DRAIN:
- Count clk cycles up to num_words + WR_OVERHEAD, then DONE.
- The sum is computed at 33 bits; no overflow for legal lengths.

DONE:
- Owner's done = 1 for one cycle (err as determined above), then IDLE.
- A new grant is possible in the cycle after DONE, giving 1 idle cycle minimum between transactions.

Other rules:
- ctrl_rd_data_valid outside RD_WAIT is ignored and not forwarded.
- wr_valid outside WR_FILL, or from the non-owner, is ignored.
- A request deasserted before grant is legal and is simply not granted.

Optional Feature:
HRAM_ARB_TIMEOUT_EN:
- Defined: RD_WAIT has a watchdog that is reset on each ctrl_rd_data_valid. If it reaches TIMEOUT_CYCLES with no beat, the state goes to DONE with err = 1; beats arriving later are dropped.
- Undefined: no watchdog, and RD_WAIT waits indefinitely.

Test Plan:
- Read: req0 read, addr 0x100, num_words 4; drive 4 ctrl_rd_data_valid beats 0xA0..0xA3. Expect: grant 1 cycle after valid, ctrl_cs one-cycle pulse with mode 00, req0_rd_data 0xA0..0xA3, req0_done = 1 with err = 0 the cycle after the 4th beat.
- Write: req1 write, num_words 3, data 0x11/0x22/0x33. Expect: 3 ctrl_wr_data_valid pushes in order, then ctrl_cs with mode 01, then done exactly 3 + WR_OVERHEAD cycles after the ctrl_cs cycle.
- Simultaneous requests, both valid continuously for 4 transactions of 1 word each. Expect grant order req0, req1, req0, req1.
- num_words = 0 gives done with err = 0 and no ctrl_cs. num_words = 513 gives done with err = 1 and no ctrl_cs. mem_ready = 0 gives no grant; grant follows after mem_ready rises.
- rst_n low during RD_WAIT after 2 of 8 beats. Expect all outputs 0 immediately; after release, the next request proceeds normally with no stray done.
- With HRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16: read of 4 words, only 1 beat delivered. Expect done with err = 1 16 cycles after that beat.
